wm_phase_timer: RTL and testbench
=================================

Name: wm_phase_timer

Overview:
- Parametrised phase timer for the washing-machine controller. Successor to the fixed one-minute phase timer.
- Per-phase duration in minutes:seconds is loaded at start; ticks-per-second is selectable; pause, abort and restart are supported.
- Reports elapsed and remaining time and emits a one-cycle done pulse.
- Driven by the main controller FSM; one instance per phase sequencer.

Parameters:
- TICK_BASE, 1000000, clock ticks per second at freq select 0; sim benches use 4.
- MIN_W, 4, minute field width; max duration (2^MIN_W-1):59.
- SEL_W, 2, freq select width; ticks per second = TICK_BASE << clk_freq_timer.
- CNT_W, 32, prescaler counter width; must hold (TICK_BASE << (2^SEL_W-1)) - 1.

Ports:
- clk_timer  in  1  system clock
- rst_timer  in  1  synchronous reset, active-high
- start_timer  in  1  pulse; latch duration and freq select, begin counting
- pause_timer  in  1  level; counting frozen while high
- abort_timer  in  1  pulse; return to IDLE, clear counters
- clk_freq_timer  in  SEL_W  tick-rate select, sampled only on start
- dur_min  in  MIN_W  programmed minutes
- dur_sec  in  6  programmed seconds, 0..59; values above 59 are clamped to 59 at latch
- sec_flag  out  6  elapsed seconds, 0..59
- min_flag  out  MIN_W  elapsed minutes
- rem_sec  out  6  remaining seconds
- rem_min  out  MIN_W  remaining minutes
- busy  out  1  high in RUN or PAUSED
- paused  out  1  high in PAUSED
- finished  out  1  one-cycle pulse on completion

Behaviour:
- Synchronous reset:
  - state becomes IDLE.
  - ticks, sec_flag, min_flag, latched duration, rem_* and latched select clear to 0.
  - busy, paused and finished clear to 0.
  - Reset has priority over every other input and overrides any mid-run state.
- States: IDLE, RUN, PAUSED, DONE.
- Input priority when several are asserted together: reset > abort > start > pause.
- abort (any state): next state IDLE; counters and elapsed clear; finished stays 0.
- start (any state, including RUN, PAUSED or DONE; a start in these states restarts the timer):
  - Latch dur_min, dur_sec (clamped) and tps = TICK_BASE << clk_freq_timer.
  - Clear ticks and elapsed.
  - Next state RUN, or PAUSED if pause_timer is also high.
- RUN:
  - Each cycle, ticks increments.
  - When ticks == tps-1: ticks wraps to 0 and seconds advance.
  - When sec reaches 59, it wraps to 0 and min increments.
  - Changes to clk_freq_timer mid-run are ignored.
- Completion: on the edge where the updated elapsed value equals the latched duration:
  - State goes to DONE and finished is high for exactly one cycle.
  - Elapsed holds the duration; rem_* read 0.
- Zero duration (0:00): finished pulses on the first edge after the start edge; state then goes to DONE.
- Latency: with start sampled at edge E0, sec_flag = N after edge E(N*tps), and finished is high after edge E(D*tps), where D is the duration in seconds.
- RUN to PAUSED: when pause_timer is high; ticks and elapsed are held exactly.
- PAUSED to RUN: when pause_timer is low; counting resumes from the held tick value with no lost or extra ticks.
- DONE: holds its outputs until start or abort; pause is ignored.
- IDLE: pause is ignored; outputs stay at 0.
- rem = duration - elapsed. Computed combinationally in total seconds and split into min:sec, or computed from registered borrow logic; either way it must be valid in the same cycle as elapsed.
- Minute overflow cannot occur, because completion happens at or before the maximum duration.

Decomposition:
- Shared package wm_pkg holds:
  - Controller state encodings: Idle, Filling_water, Washing, Rinsing, Spinning, Pause.
  - Freq select codes: freq_1, freq_2, freq_4, freq_8.
  - Timer state localparams: IDLE, RUN, PAUSED, DONE.
- One sub-module, wm_sec_prescaler:
  - Tick counter with load of tps, an enable, and a one-cycle sec_tick output.
  - The min:sec counter and FSM stay in the top module.

Test Plan:
- TICK_BASE=4, sel=0, duration 0:03 -> sec_flag steps to 1/2/3 at E4/E8/E12; finished high exactly after E12 for 1 cycle; rem = 0:00; busy drops.
- sel=2 (tps 16), duration 1:01 -> at E960 sec 59→0 and min 0→1; finished after E976; elapsed reads 1:01.
- duration 0:02, pause high from E5 to E15 -> sec_flag holds at 1 during the pause; finished after E18 (8 + 10 paused cycles).
- Abort at E6 during a 0:05 run -> IDLE next cycle; sec_flag = 0; finished never asserts. Restart with 0:01 -> finished after E4.
- start and abort in the same cycle -> IDLE. Start with dur 0:00 -> finished after E1. Reset mid-run -> all outputs 0 the next cycle.
- dur_sec = 63 -> clamped to 0:59; finished after E236; clk_freq_timer toggled mid-run has no effect on timing.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller and its phase timer.
package wm_pkg;

    // Main controller state encodings.
    typedef enum logic [2:0] {
        Idle,
        Filling_water,
        Washing,
        Rinsing,
        Spinning,
        Pause
    } ctrl_state_e;

    // Tick-rate select codes: ticks per second = TICK_BASE << code.
    typedef enum logic [1:0] {
        freq_1,
        freq_2,
        freq_4,
        freq_8
    } freq_sel_e;

    // Phase timer states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } timer_state_e;

    localparam logic [5:0] SEC_MAX = 6'd59;

    // Programmed seconds above 59 are treated as 59.
    function automatic logic [5:0] clamp_sec(input logic [5:0] s);
        return (s > SEC_MAX) ? SEC_MAX : s;
    endfunction

endpackage

// File: rtl/wm_phase_timer_if.sv
// Control/status bundle between the controller FSM (master) and a phase timer (slave).
interface wm_phase_timer_if #(
    parameter int MIN_W = 4,
    parameter int SEL_W = 2
) ();
    logic             start_timer;
    logic             pause_timer;
    logic             abort_timer;
    logic [SEL_W-1:0] clk_freq_timer;
    logic [MIN_W-1:0] dur_min;
    logic [5:0]       dur_sec;
    logic [5:0]       sec_flag;
    logic [MIN_W-1:0] min_flag;
    logic [5:0]       rem_sec;
    logic [MIN_W-1:0] rem_min;
    logic             busy;
    logic             paused;
    logic             finished;

    modport master (
        output start_timer, pause_timer, abort_timer, clk_freq_timer, dur_min, dur_sec,
        input  sec_flag, min_flag, rem_sec, rem_min, busy, paused, finished
    );

    modport slave (
        input  start_timer, pause_timer, abort_timer, clk_freq_timer, dur_min, dur_sec,
        output sec_flag, min_flag, rem_sec, rem_min, busy, paused, finished
    );
endinterface

// File: rtl/wm_sec_prescaler.sv
// Divides the system clock down to a one-cycle pulse per second at the latched rate.
module wm_sec_prescaler #(
    parameter int TICK_BASE = 1000000,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk_timer,
    input  logic             rst_timer,
    input  logic             load,
    input  logic [SEL_W-1:0] sel,
    input  logic             clear,
    input  logic             en,
    output logic             sec_tick
);
    logic [CNT_W-1:0] tps_q, tps_d;
    logic [CNT_W-1:0] ticks_q, ticks_d;
    logic             wrap;

    assign wrap     = (ticks_q == tps_q - CNT_W'(1));
    assign sec_tick = en && wrap;

    // Next tick count and rate: clear wins over load, load wins over counting.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        tps_d   = tps_q;
        ticks_d = ticks_q;
        if (clear) begin
            tps_d   = '0;
            ticks_d = '0;
        end else if (load) begin
            tps_d   = CNT_W'(TICK_BASE) << sel;
            ticks_d = '0;
        end else if (en) begin
            ticks_d = wrap ? '0 : ticks_q + CNT_W'(1);
        end
    end

    // Rate and tick registers.
    always_ff @(posedge clk_timer) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst_timer) begin
            tps_q   <= '0;
            ticks_q <= '0;
        end else begin
            tps_q   <= tps_d;
            ticks_q <= ticks_d;
        end
    end
endmodule

// File: rtl/wm_phase_timer.sv
// Phase timer: counts elapsed min:sec up to a latched duration, with pause/abort/restart.
module wm_phase_timer
    import wm_pkg::*;
#(
    parameter int TICK_BASE = 1000000,
    parameter int MIN_W     = 4,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk_timer,
    input  logic             rst_timer,
    wm_phase_timer_if.slave  bus
);
    timer_state_e     state_q, state_d;
    logic [5:0]       sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [5:0]       dur_sec_q, dur_sec_d;
    logic [MIN_W-1:0] dur_min_q, dur_min_d;
    logic             finished_q, finished_d;
    logic             cnt_en;
    logic             sec_tick;
    logic             load;
    logic [5:0]       sec_nxt;
    logic [MIN_W-1:0] min_nxt;
    logic             sec_borrow;
    logic [6:0]       rem_sec_w;

    // Counting happens only in RUN/PAUSED with no command and pause released.
    assign cnt_en = ((state_q == RUN) || (state_q == PAUSED)) && !bus.abort_timer
                    && !bus.start_timer && !bus.pause_timer;
    assign load   = bus.start_timer && !bus.abort_timer;

    wm_sec_prescaler #(
        .TICK_BASE (TICK_BASE),
        .SEL_W     (SEL_W),
        .CNT_W     (CNT_W)
    ) u_prescaler (
        .clk_timer (clk_timer),
        .rst_timer (rst_timer),
        .load      (load),
        .sel       (bus.clk_freq_timer),
        .clear     (bus.abort_timer),
        .en        (cnt_en),
        .sec_tick  (sec_tick)
    );

    // Elapsed value after this edge if counting proceeds.
    always_comb begin
        sec_nxt = sec_q;
        min_nxt = min_q;
        if (sec_tick) begin
            if (sec_q == SEC_MAX) begin
                sec_nxt = '0;
                min_nxt = min_q + MIN_W'(1);
            end else begin
                sec_nxt = sec_q + 6'd1;
            end
        end
    end

    // Next state and datapath; priority abort > start > pause.
    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        min_d      = min_q;
        dur_sec_d  = dur_sec_q;
        dur_min_d  = dur_min_q;
        finished_d = 1'b0;
        if (bus.abort_timer) begin
            state_d   = IDLE;
            sec_d     = '0;
            min_d     = '0;
            dur_sec_d = '0;
            dur_min_d = '0;
        end else if (bus.start_timer) begin
            state_d   = bus.pause_timer ? PAUSED : RUN;
            sec_d     = '0;
            min_d     = '0;
            dur_sec_d = clamp_sec(bus.dur_sec);
            dur_min_d = bus.dur_min;
        end else begin
            case (state_q)
                RUN, PAUSED: begin
                    if (bus.pause_timer) begin
                        state_d = PAUSED;
                    end else begin
                        sec_d = sec_nxt;
                        min_d = min_nxt;
                        if ((sec_nxt == dur_sec_q) && (min_nxt == dur_min_q)) begin
                            state_d    = DONE;
                            finished_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, elapsed, duration and done-pulse registers.
    always_ff @(posedge clk_timer) begin
        if (rst_timer) begin
            state_q    <= IDLE;
            sec_q      <= '0;
            min_q      <= '0;
            dur_sec_q  <= '0;
            dur_min_q  <= '0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            dur_sec_q  <= dur_sec_d;
            dur_min_q  <= dur_min_d;
            finished_q <= finished_d;
        end
    end

    // Remaining time by min:sec borrow subtraction; elapsed never exceeds duration.
    assign sec_borrow = sec_q > dur_sec_q;
    assign rem_sec_w  = sec_borrow ? (7'(dur_sec_q) + 7'd60 - 7'(sec_q))
                                   : (7'(dur_sec_q) - 7'(sec_q));

    assign bus.rem_sec  = rem_sec_w[5:0];
    assign bus.rem_min  = dur_min_q - min_q - MIN_W'(sec_borrow);
    assign bus.sec_flag = sec_q;
    assign bus.min_flag = min_q;
    assign bus.busy     = (state_q == RUN) || (state_q == PAUSED);
    assign bus.paused   = (state_q == PAUSED);
    assign bus.finished = finished_q;
endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer with TICK_BASE = 4.
module tb_wm_phase_timer;
    logic clk_timer;
    logic rst_timer;
    int   n_cmp;
    int   n_err;
    int   fin_cnt;

    wm_phase_timer_if #(.MIN_W(4), .SEL_W(2)) bus ();

    wm_phase_timer #(
        .TICK_BASE (4),
        .MIN_W     (4),
        .SEL_W     (2),
        .CNT_W     (32)
    ) dut (
        .clk_timer (clk_timer),
        .rst_timer (rst_timer),
        .bus       (bus)
    );

    initial clk_timer = 1'b0;
    always #5 clk_timer = ~clk_timer;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_timer);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [3:0] m, input logic [5:0] s, input logic [1:0] sel);
        bus.dur_min        = m;
        bus.dur_sec        = s;
        bus.clk_freq_timer = sel;
        bus.start_timer    = 1'b1;
        tick(1);
        bus.start_timer    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.start_timer    = 1'b0;
        bus.pause_timer    = 1'b0;
        bus.abort_timer    = 1'b0;
        bus.clk_freq_timer = 2'd0;
        bus.dur_min        = 4'd0;
        bus.dur_sec        = 6'd0;
        rst_timer          = 1'b1;
        tick(2);
        rst_timer = 1'b0;

        // Reset state
        check("rst_sec", bus.sec_flag, 0);
        check("rst_min", bus.min_flag, 0);
        check("rst_rem_sec", bus.rem_sec, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_fin", bus.finished, 0);

        // 0:03 at tps 4
        do_start(4'd0, 6'd3, 2'd0);
        check("t1_busy_e0", bus.busy, 1);
        check("t1_rem_e0", bus.rem_sec, 3);
        tick(3);
        check("t1_sec_e3", bus.sec_flag, 0);
        tick(1);
        check("t1_sec_e4", bus.sec_flag, 1);
        check("t1_rem_e4", bus.rem_sec, 2);
        tick(4);
        check("t1_sec_e8", bus.sec_flag, 2);
        tick(3);
        check("t1_fin_e11", bus.finished, 0);
        tick(1);
        check("t1_sec_e12", bus.sec_flag, 3);
        check("t1_fin_e12", bus.finished, 1);
        check("t1_rem_e12", bus.rem_sec, 0);
        check("t1_busy_e12", bus.busy, 0);
        tick(1);
        check("t1_fin_e13", bus.finished, 0);
        check("t1_hold_e13", bus.sec_flag, 3);

        // 1:01 at tps 16 (minute rollover)
        do_start(4'd1, 6'd1, 2'd2);
        check("t2_rem_min_e0", bus.rem_min, 1);
        tick(959);
        check("t2_sec_e959", bus.sec_flag, 59);
        check("t2_min_e959", bus.min_flag, 0);
        tick(1);
        check("t2_sec_e960", bus.sec_flag, 0);
        check("t2_min_e960", bus.min_flag, 1);
        check("t2_rem_sec_e960", bus.rem_sec, 1);
        check("t2_rem_min_e960", bus.rem_min, 0);
        tick(15);
        check("t2_fin_e975", bus.finished, 0);
        tick(1);
        check("t2_fin_e976", bus.finished, 1);
        check("t2_min_e976", bus.min_flag, 1);
        check("t2_sec_e976", bus.sec_flag, 1);

        // 0:02 with pause sampled high at E5..E14
        do_start(4'd0, 6'd2, 2'd0);
        tick(4);
        check("t3_sec_e4", bus.sec_flag, 1);
        bus.pause_timer = 1'b1;
        tick(1);
        check("t3_paused_e5", bus.paused, 1);
        check("t3_busy_e5", bus.busy, 1);
        tick(9);
        check("t3_sec_e14", bus.sec_flag, 1);
        bus.pause_timer = 1'b0;
        tick(3);
        check("t3_paused_e17", bus.paused, 0);
        check("t3_fin_e17", bus.finished, 0);
        check("t3_sec_e17", bus.sec_flag, 1);
        tick(1);
        check("t3_fin_e18", bus.finished, 1);
        check("t3_sec_e18", bus.sec_flag, 2);

        // Abort at E6 of a 0:05 run, then restart with 0:01
        do_start(4'd0, 6'd5, 2'd0);
        tick(5);
        bus.abort_timer = 1'b1;
        tick(1);
        bus.abort_timer = 1'b0;
        check("t4_busy_abort", bus.busy, 0);
        check("t4_sec_abort", bus.sec_flag, 0);
        check("t4_rem_abort", bus.rem_sec, 0);
        fin_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.finished) fin_cnt++;
            tick(1);
        end
        check("t4_no_fin", fin_cnt, 0);
        do_start(4'd0, 6'd1, 2'd0);
        tick(3);
        check("t4_fin_e3", bus.finished, 0);
        tick(1);
        check("t4_fin_e4", bus.finished, 1);

        // Start and abort together -> IDLE
        bus.abort_timer = 1'b1;
        do_start(4'd0, 6'd4, 2'd0);
        bus.abort_timer = 1'b0;
        check("t5_sa_busy", bus.busy, 0);
        check("t5_sa_rem", bus.rem_sec, 0);

        // Zero duration
        do_start(4'd0, 6'd0, 2'd0);
        check("t5_zero_busy_e0", bus.busy, 1);
        check("t5_zero_fin_e0", bus.finished, 0);
        tick(1);
        check("t5_zero_fin_e1", bus.finished, 1);
        check("t5_zero_busy_e1", bus.busy, 0);

        // Start with pause high enters PAUSED
        bus.pause_timer = 1'b1;
        do_start(4'd0, 6'd1, 2'd0);
        check("t5_start_paused", bus.paused, 1);
        bus.pause_timer = 1'b0;

        // Reset mid-run
        do_start(4'd0, 6'd5, 2'd0);
        tick(7);
        rst_timer = 1'b1;
        tick(1);
        rst_timer = 1'b0;
        check("t5_rst_sec", bus.sec_flag, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_rem", bus.rem_sec, 0);
        check("t5_rst_fin", bus.finished, 0);

        // dur_sec 63 clamps to 59; select toggled mid-run is ignored
        do_start(4'd0, 6'd63, 2'd0);
        check("t6_rem_clamp", bus.rem_sec, 59);
        for (int i = 0; i < 235; i++) begin
            bus.clk_freq_timer = 2'(i);
            tick(1);
        end
        check("t6_fin_e235", bus.finished, 0);
        check("t6_sec_e235", bus.sec_flag, 58);
        tick(1);
        check("t6_fin_e236", bus.finished, 1);
        check("t6_sec_e236", bus.sec_flag, 59);
        check("t6_min_e236", bus.min_flag, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
